// File: rtl/multicycle_control_unit_if.sv
// Handshake and datapath strobe bundle of multicycle_control_unit.
// The slave modport is the control unit; the master modport is the
// fetch/datapath side driving opcodes, flags and memory completion.
interface multicycle_control_unit_if #(
   parameter int OPCODE_W = 4
);
   logic                instr_valid;
   logic [OPCODE_W-1:0] opcode;
   logic                instr_ready;
   logic                zero_flag;
   logic                mem_ready;
   logic                reg_write;
   logic                alu_src;
   logic                jump;
   logic                branch_taken;
   logic                pc_en;
   logic                mem_read;
   logic                mem_write;
   logic [2:0]          alu_op;
   logic                illegal_op;
   logic                mem_err;
   logic                halted;

   modport master (
      output instr_valid, opcode, zero_flag, mem_ready,
      input  instr_ready, reg_write, alu_src, jump, branch_taken, pc_en,
             mem_read, mem_write, alu_op, illegal_op, mem_err, halted
   );

   modport slave (
      input  instr_valid, opcode, zero_flag, mem_ready,
      output instr_ready, reg_write, alu_src, jump, branch_taken, pc_en,
             mem_read, mem_write, alu_op, illegal_op, mem_err, halted
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle Moore control unit for the 8-bit processor.
// FETCH -> DECODE -> EXEC/MEM -> WB, with a bounded MEM phase (timeout counter).
// Optional macro MCU_ILLEGAL_TRAP_EN: illegal opcodes trap into HALT instead of
// retiring as a NOP.
module multicycle_control_unit #(
   parameter int OPCODE_W    = 4,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   multicycle_control_unit_if.slave bus
);
   localparam int              CNT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [2:0]       ALU_IDLE = 3'b111;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_ALU, C_JMP, C_BEQ, C_BNE, C_LOAD, C_STORE, C_HALT, C_ILL
   } op_class_t;

   state_t              state_q, state_d;
   logic [OPCODE_W-1:0] ir_q, ir_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   op_class_t           cls_s;

   // Any bit above bit 3 set, or codes B..E, makes the opcode illegal.
   function automatic op_class_t classify(input logic [OPCODE_W-1:0] code);
      op_class_t c;
      if ((code >> 3'd4) != {OPCODE_W{1'b0}}) begin
         c = C_ILL;
      end else begin
         case (code[3:0])
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: c = C_ALU;
            4'h6:    c = C_JMP;
            4'h7:    c = C_BEQ;
            4'h8:    c = C_LOAD;
            4'h9:    c = C_STORE;
            4'hA:    c = C_BNE;
            4'hF:    c = C_HALT;
            default: c = C_ILL;
         endcase
      end
      return c;
   endfunction

   // ALU function for an opcode; anything that is not an ALU op reads idle.
   function automatic logic [2:0] alu_code(input logic [OPCODE_W-1:0] code);
      logic [2:0] f;
      case (code[3:0])
         4'h0, 4'h1: f = 3'b100;
         4'h2:       f = 3'b000;
         4'h3:       f = 3'b001;
         4'h4:       f = 3'b010;
         4'h5:       f = 3'b011;
         default:    f = ALU_IDLE;
      endcase
      return f;
   endfunction

   assign cls_s = classify(ir_q);

   // State, instruction register and MEM timeout counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_FETCH;
         ir_q    <= {OPCODE_W{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; the counter is cleared on the way into MEM.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_FETCH: begin
            if (bus.instr_valid) begin
               ir_d    = bus.opcode;
               state_d = S_DECODE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            case (cls_s)
               C_ALU, C_JMP, C_BEQ, C_BNE: state_d = S_EXEC;
               C_LOAD, C_STORE: begin
                  state_d = S_MEM;
                  cnt_d   = {CNT_W{1'b0}};
               end
               C_HALT: state_d = S_HALT;
`ifdef MCU_ILLEGAL_TRAP_EN
               C_ILL:   state_d = S_HALT;
`else
               C_ILL:   state_d = S_FETCH;
`endif
               default: state_d = S_FETCH;
            endcase
         end
         S_EXEC: begin
            if (cls_s == C_ALU) begin
               state_d = S_WB;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_MEM: begin
            if (bus.mem_ready) begin
               state_d = (cls_s == C_LOAD) ? S_WB : S_FETCH;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_FETCH;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_WB:    state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // Strobe decode from state and IR; everything is forced idle while rst is high.
   always_comb begin
      bus.instr_ready  = 1'b0;
      bus.reg_write    = 1'b0;
      bus.alu_src      = 1'b0;
      bus.jump         = 1'b0;
      bus.branch_taken = 1'b0;
      bus.pc_en        = 1'b0;
      bus.mem_read     = 1'b0;
      bus.mem_write    = 1'b0;
      bus.alu_op       = ALU_IDLE;
      bus.illegal_op   = 1'b0;
      bus.mem_err      = 1'b0;
      bus.halted       = 1'b0;
      if (rst_i) begin
         bus.alu_op = ALU_IDLE;
      end else begin
         case (state_q)
            S_FETCH: bus.instr_ready = 1'b1;
            S_DECODE: begin
               if (cls_s == C_ILL) begin
                  bus.illegal_op = 1'b1;
`ifdef MCU_ILLEGAL_TRAP_EN
                  bus.pc_en      = 1'b0;
`else
                  bus.pc_en      = 1'b1;
`endif
               end else begin
                  bus.illegal_op = 1'b0;
               end
            end
            S_EXEC: begin
               case (cls_s)
                  C_ALU: begin
                     bus.alu_op  = alu_code(ir_q);
                     bus.alu_src = (ir_q[3:0] == 4'h0);
                  end
                  C_JMP: begin
                     bus.jump  = 1'b1;
                     bus.pc_en = 1'b1;
                  end
                  C_BEQ: begin
                     bus.branch_taken = bus.zero_flag;
                     bus.pc_en        = 1'b1;
                  end
                  C_BNE: begin
                     bus.branch_taken = ~bus.zero_flag;
                     bus.pc_en        = 1'b1;
                  end
                  default: bus.alu_op = ALU_IDLE;
               endcase
            end
            S_MEM: begin
               bus.mem_read  = (cls_s == C_LOAD);
               bus.mem_write = (cls_s == C_STORE);
               if (bus.mem_ready) begin
                  bus.pc_en = (cls_s == C_STORE);
               end else if (cnt_q == CNT_LAST) begin
                  bus.mem_err = 1'b1;
                  bus.pc_en   = 1'b1;
               end else begin
                  bus.pc_en = 1'b0;
               end
            end
            S_WB: begin
               bus.reg_write = 1'b1;
               bus.pc_en     = 1'b1;
               bus.alu_op    = alu_code(ir_q);
               bus.alu_src   = (cls_s == C_ALU) && (ir_q[3:0] == 4'h0);
            end
            S_HALT:  bus.halted = 1'b1;
            default: bus.alu_op = ALU_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed test-plan steps
// followed by random instructions, each checked cycle by cycle against an
// instruction-level trace model.
module tb_multicycle_control_unit;
   localparam int OW = 5;
   localparam int TO = 16;

   typedef struct packed {
      logic       instr_ready;
      logic       reg_write;
      logic       alu_src;
      logic       jump;
      logic       branch_taken;
      logic       pc_en;
      logic       mem_read;
      logic       mem_write;
      logic [2:0] alu_op;
      logic       illegal_op;
      logic       mem_err;
      logic       halted;
   } out_t;

   localparam logic [2:0] ALU_TAB [6] = '{3'b100, 3'b100, 3'b000, 3'b001, 3'b010, 3'b011};

   logic clk;
   logic rst;
   int   compared;
   int   mismatched;
   out_t exp_q[$];
   logic mr_q[$];

   multicycle_control_unit_if #(.OPCODE_W(OW)) bus ();

   multicycle_control_unit #(.OPCODE_W(OW), .MEM_TIMEOUT(TO)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic out_t idle_o();
      out_t o;
      o        = '0;
      o.alu_op = 3'b111;
      return o;
   endfunction

   function automatic out_t sample();
      out_t o;
      o.instr_ready  = bus.instr_ready;
      o.reg_write    = bus.reg_write;
      o.alu_src      = bus.alu_src;
      o.jump         = bus.jump;
      o.branch_taken = bus.branch_taken;
      o.pc_en        = bus.pc_en;
      o.mem_read     = bus.mem_read;
      o.mem_write    = bus.mem_write;
      o.alu_op       = bus.alu_op;
      o.illegal_op   = bus.illegal_op;
      o.mem_err      = bus.mem_err;
      o.halted       = bus.halted;
      return o;
   endfunction

   task automatic check(input string tag, input out_t exp);
      out_t obs;
      obs = sample();
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b (rdy,rw,src,jmp,br,pc,mr,mw,alu[3],ill,merr,halt)",
                tag, obs, exp);
      end
   endtask

   task automatic push(input out_t o, input logic mr);
      exp_q.push_back(o);
      mr_q.push_back(mr);
   endtask

   // Expected per-cycle outputs of one instruction, from its handshake cycle on.
   // m is the MEM cycle (1-based) on which mem_ready arrives; m > TO means never.
   task automatic build(input logic [OW-1:0] op, input logic zf, input int m);
      out_t o;
      int   k;
      bit   done;
      bit   illegal;
      exp_q.delete();
      mr_q.delete();
      o = idle_o();
      o.instr_ready = 1'b1;
      push(o, 1'($urandom));
      o = idle_o();
      illegal = (op > 15) || (op >= 11 && op <= 14);
      if (illegal) begin
         o.illegal_op = 1'b1;
`ifdef MCU_ILLEGAL_TRAP_EN
         push(o, 1'($urandom));
         o = idle_o();
         o.halted = 1'b1;
         repeat (4) push(o, 1'($urandom));
`else
         o.pc_en = 1'b1;
         push(o, 1'($urandom));
`endif
      end else begin
         push(o, 1'($urandom));
         o = idle_o();
         if (op <= 5) begin
            o.alu_op  = ALU_TAB[op];
            o.alu_src = (op == 0);
            push(o, 1'($urandom));
            o.reg_write = 1'b1;
            o.pc_en     = 1'b1;
            push(o, 1'($urandom));
         end else if (op == 6) begin
            o.jump  = 1'b1;
            o.pc_en = 1'b1;
            push(o, 1'($urandom));
         end else if (op == 7 || op == 10) begin
            o.branch_taken = (op == 7) ? zf : ~zf;
            o.pc_en        = 1'b1;
            push(o, 1'($urandom));
         end else if (op == 8 || op == 9) begin
            done = (m <= TO);
            k    = done ? m : TO;
            for (int j = 1; j <= k; j++) begin
               o = idle_o();
               o.mem_read  = (op == 8);
               o.mem_write = (op == 9);
               if (j == k) begin
                  o.mem_err = !done;
                  o.pc_en   = !done || (op == 9);
               end
               push(o, (j == m));
            end
            if (op == 8 && done) begin
               o = idle_o();
               o.reg_write = 1'b1;
               o.pc_en     = 1'b1;
               push(o, 1'($urandom));
            end
         end else begin
            o.halted = 1'b1;
            repeat (4) push(o, 1'($urandom));
         end
      end
   endtask

   // Runs one instruction with instr_valid held high throughout; abort_at >= 0
   // asserts rst on that trace cycle. halted_o reports a HALT ending.
   task automatic run_instr(input logic [OW-1:0] op, input logic zf, input int m,
                            input int abort_at, output bit halted_o);
      build(op, zf, m);
      halted_o = exp_q[exp_q.size() - 1].halted;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         rst             = (i == abort_at);
         bus.instr_valid = 1'b1;
         bus.opcode      = (i == 0) ? op : OW'($urandom);
         bus.zero_flag   = zf;
         bus.mem_ready   = mr_q[i];
         #1;
         if (i == abort_at) begin
            check($sformatf("op%0h rst@%0d", op, i), idle_o());
            halted_o = 1'b0;
            break;
         end else begin
            check($sformatf("op%0h cyc%0d", op, i), exp_q[i]);
         end
      end
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst             = 1'b1;
         bus.instr_valid = 1'($urandom);
         bus.mem_ready   = 1'($urandom);
         #1;
         check($sformatf("reset%0d", i), idle_o());
      end
   endtask

   task automatic idle_cycles(input int n);
      out_t o;
      o = idle_o();
      o.instr_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst             = 1'b0;
         bus.instr_valid = 1'b0;
         bus.opcode      = OW'($urandom);
         bus.mem_ready   = 1'($urandom);
         #1;
         check("fetch_idle", o);
      end
   endtask

   initial begin
      bit           h;
      logic [OW-1:0] op;
      compared        = 0;
      mismatched      = 0;
      rst             = 1'b1;
      bus.instr_valid = 1'b0;
      bus.opcode      = '0;
      bus.zero_flag   = 1'b0;
      bus.mem_ready   = 1'b0;

      do_reset(3);
      run_instr(5'h02, 1'b0, 1, -1, h);        // ADD
      run_instr(5'h07, 1'b1, 1, -1, h);        // BEQ taken
      run_instr(5'h0A, 1'b1, 1, -1, h);        // BNE not taken
      run_instr(5'h08, 1'b0, 3, -1, h);        // LOAD, ready on 3rd MEM cycle
      run_instr(5'h09, 1'b0, TO + 1, -1, h);   // STORE timeout
      run_instr(5'h09, 1'b0, TO, -1, h);       // STORE, ready on last allowed cycle
      run_instr(5'h0C, 1'b0, 1, -1, h);        // illegal
      if (h) do_reset(1);
      idle_cycles(2);
      run_instr(5'h0F, 1'b0, 1, -1, h);        // HALT
      do_reset(1);
      run_instr(5'h08, 1'b0, TO + 1, 3, h);    // LOAD cut by rst in MEM
      run_instr(5'h00, 1'b1, 1, -1, h);        // LDI after reset
      run_instr(5'h13, 1'b0, 1, -1, h);        // upper-bit illegal
      if (h) do_reset(1);

      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            op = OW'($urandom_range(16, 31));
         end else begin
            op = OW'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 4) == 0) idle_cycles($urandom_range(1, 2));
         run_instr(op, 1'($urandom), $urandom_range(1, TO + 2), -1, h);
         if (h) do_reset($urandom_range(1, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
